// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin select arbiter.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

    // Requester slots as wired to the shared datapath mux inputs.
    localparam logic [1:0] REQ_PC  = 2'd0;
    localparam logic [1:0] REQ_ALU = 2'd1;
    localparam logic [1:0] REQ_MDR = 2'd2;
    localparam logic [1:0] REQ_IMM = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or after Ptr, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] Req,
    input  logic [1:0] Ptr,
    output logic [1:0] Winner,
    output logic       Any
);

    logic [3:0] rotReq;

    // rotReq[k] is the request sitting k slots after the pointer.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : gRot
        logic [1:0] srcIdx;
        assign srcIdx     = Ptr + 2'(gi);
        assign rotReq[gi] = Req[srcIdx];
    end

    always_comb begin
        Winner = Ptr;
        for (int k = 3; k >= 0; k--) begin
            if (rotReq[k]) begin
                Winner = Ptr + 2'(k);
            end
        end
    end

    assign Any = |Req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 select path, with a bounded hold time and one turnaround cycle.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic [1:0] Sel,
    output logic       GrantValid,
    output logic       Preempt
);

    arbState_e        stateReg, stateNext;
    logic [1:0]       ptrReg, ptrNext;
    logic [1:0]       selReg, selNext;
    logic [CNT_W-1:0] holdCntReg, holdCntNext;
    logic [3:0]       grantReg, grantNext;
    logic             validReg, validNext;
    logic             preemptReg, preemptNext;

    logic [1:0] pickIdx;
    logic       pickAny;
    logic       ownerReq;
    logic [3:0] others;
    logic       holdExpired;
    logic       releaseNow;
    logic       preemptNow;

    rr_pick4 uPick (
        .Req    (Req),
        .Ptr    (ptrReg),
        .Winner (pickIdx),
        .Any    (pickAny)
    );

    // While busy, selReg is the owner and grantReg is its one-hot.
    assign ownerReq    = Req[selReg];
    assign others      = Req & ~grantReg;
    assign holdExpired = (holdCntReg == CNT_W'(MAX_HOLD - 1));
    assign releaseNow  = ~ownerReq;
    assign preemptNow  = ownerReq && holdExpired && (others != 4'b0000);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg   <= IDLE;
            ptrReg     <= 2'd0;
            selReg     <= 2'd0;
            holdCntReg <= '0;
            grantReg   <= 4'b0000;
            validReg   <= 1'b0;
            preemptReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            ptrReg     <= ptrNext;
            selReg     <= selNext;
            holdCntReg <= holdCntNext;
            grantReg   <= grantNext;
            validReg   <= validNext;
            preemptReg <= preemptNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (pickAny) stateNext = BUSY;
            BUSY:    if (releaseNow || preemptNow) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ptrNext     = ptrReg;
        selNext     = selReg;
        holdCntNext = holdCntReg;
        grantNext   = grantReg;
        validNext   = validReg;
        preemptNext = 1'b0;
        case (stateReg)
            IDLE: begin
                grantNext = 4'b0000;
                validNext = 1'b0;
                if (pickAny) begin
                    grantNext   = onehot4(pickIdx);
                    selNext     = pickIdx;
                    validNext   = 1'b1;
                    holdCntNext = '0;
                end
            end
            BUSY: begin
                // Sel keeps the departing owner so the mux input stays stable.
                if (releaseNow || preemptNow) begin
                    grantNext   = 4'b0000;
                    validNext   = 1'b0;
                    ptrNext     = selReg + 2'd1;
                    preemptNext = ~releaseNow;
                end else if (!(holdExpired && (others == 4'b0000))) begin
                    holdCntNext = holdCntReg + CNT_W'(1);
                end
            end
            default: begin
                grantNext = 4'b0000;
                validNext = 1'b0;
            end
        endcase
    end

    assign Grant      = grantReg;
    assign Sel        = selReg;
    assign GrantValid = validReg;
    assign Preempt    = preemptReg;

endmodule
